dc_port_arb: RTL and testbench

- Two-requester arbiter for the single dcache request/response port.
- Requester 0 is the load-store queue: loads and stores, tagged by a 4-bit lsqid.
- Requester 1 is an auxiliary load-only client (page-table walker / debug read).
- Requests are muxed onto the dcache port with a source tag, and responses are routed back.
- Tracks outstanding LSQ loads so that responses for loads squashed by a pipeline flush are silently dropped, and guarantees bounded aux latency with a starvation counter.

---
 rtl/dc_port_arb.sv | 118 +++++++++++
 tb/tb_dc_port_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_port_arb.sv
// Two-requester arbiter for the dcache port: the LSQ and an aux load-only client.
// Tracks outstanding LSQ loads, drops responses squashed by a flush, and bounds aux wait time.
module dc_port_arb #(
    parameter int STARVE_LIMIT = 8,
    parameter int CW           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsq_dc_req,
    input  logic [3:0]  lsq_dc_op,
    input  logic [31:0] lsq_dc_addr,
    input  logic [3:0]  lsq_dc_lsqid,
    input  logic [31:0] lsq_dc_wdata,
    input  logic        lsq_dc_flush,
    output logic        dcache_lsq_ready,
    output logic        dcache_lsq_valid,
    output logic        dcache_lsq_error,
    output logic [3:0]  dcache_lsq_lsqid,
    output logic [31:0] dcache_lsq_rdata,
    input  logic        aux_req,
    input  logic [31:0] aux_addr,
    output logic        aux_ready,
    output logic        aux_valid,
    output logic        aux_error,
    output logic [31:0] aux_rdata,
    output logic        arb_dc_req,
    output logic [3:0]  arb_dc_op,
    output logic [31:0] arb_dc_addr,
    output logic [4:0]  arb_dc_tag,
    output logic [31:0] arb_dc_wdata,
    output logic        arb_dc_flush,
    input  logic        dc_arb_ready,
    input  logic        dc_arb_valid,
    input  logic        dc_arb_error,
    input  logic [4:0]  dc_arb_tag,
    input  logic [31:0] dc_arb_rdata
);

    logic [15:0]   ld_pend, ld_pend_nxt;
    logic [15:0]   stale, stale_nxt;
    logic          aux_pend;
    logic [CW-1:0] starve;

    logic       lsq_is_load, lsq_elig, aux_elig;
    logic       lsq_win, aux_win, lsq_beat, aux_beat;
    logic       rsp_aux, rsp_lsq, rsp_stale;
    logic [3:0] rsp_id;

    assign lsq_is_load = ~lsq_dc_op[0];
    assign lsq_elig    = lsq_dc_req & ~lsq_dc_flush & ~(lsq_is_load & stale[lsq_dc_lsqid]);
    assign aux_elig    = aux_req & ~aux_pend;

    // Aux only pre-empts the LSQ once it has waited the full starvation window.
    assign aux_win  = aux_elig & (~lsq_elig | (starve == CW'(STARVE_LIMIT)));
    assign lsq_win  = lsq_elig & ~aux_win;
    assign lsq_beat = lsq_win & dc_arb_ready;
    assign aux_beat = aux_win & dc_arb_ready;

    assign arb_dc_req   = lsq_elig | aux_elig;
    assign arb_dc_op    = aux_win ? 4'b0100 : lsq_dc_op;
    assign arb_dc_addr  = aux_win ? aux_addr : lsq_dc_addr;
    assign arb_dc_tag   = aux_win ? 5'b10000 : {1'b0, lsq_dc_lsqid};
    assign arb_dc_wdata = aux_win ? 32'h0 : lsq_dc_wdata;
    assign arb_dc_flush = lsq_dc_flush;

    assign dcache_lsq_ready = lsq_beat;
    assign aux_ready        = aux_beat;

    assign rsp_id    = dc_arb_tag[3:0];
    assign rsp_aux   = dc_arb_valid & dc_arb_tag[4];
    assign rsp_lsq   = dc_arb_valid & ~dc_arb_tag[4];
    assign rsp_stale = stale[rsp_id];

    assign dcache_lsq_valid = rsp_lsq & ~rsp_stale;
    assign dcache_lsq_error = dcache_lsq_valid & dc_arb_error;
    assign dcache_lsq_lsqid = dcache_lsq_valid ? rsp_id : 4'h0;
    assign dcache_lsq_rdata = dcache_lsq_valid ? dc_arb_rdata : 32'h0;

    assign aux_valid = rsp_aux;
    assign aux_error = rsp_aux & dc_arb_error;
    assign aux_rdata = rsp_aux ? dc_arb_rdata : 32'h0;

    // Order matters: a response clears before a same-cycle beat sets (id reuse),
    // and a response clear overrides a same-cycle flush marking.
    always_comb begin
        ld_pend_nxt = ld_pend;
        stale_nxt   = stale;
        if (lsq_dc_flush)
            stale_nxt = stale | ld_pend;
        if (rsp_lsq) begin
            ld_pend_nxt[rsp_id] = 1'b0;
            stale_nxt[rsp_id]   = 1'b0;
        end
        if (lsq_beat && lsq_is_load)
            ld_pend_nxt[lsq_dc_lsqid] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_pend  <= '0;
            stale    <= '0;
            aux_pend <= 1'b0;
            starve   <= '0;
        end else begin
            ld_pend <= ld_pend_nxt;
            stale   <= stale_nxt;
            if (aux_beat)
                aux_pend <= 1'b1;
            else if (rsp_aux)
                aux_pend <= 1'b0;
            if (!aux_req || aux_beat)
                starve <= '0;
            else if (starve != CW'(STARVE_LIMIT))
                starve <= starve + CW'(1);
        end
    end

endmodule

// File: tb/tb_dc_port_arb.sv
// Directed bench for dc_port_arb: hand-computed expectations checked with immediate assertions.
module tb_dc_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsq_dc_req;
    logic [3:0]  lsq_dc_op;
    logic [31:0] lsq_dc_addr;
    logic [3:0]  lsq_dc_lsqid;
    logic [31:0] lsq_dc_wdata;
    logic        lsq_dc_flush;
    logic        dcache_lsq_ready, dcache_lsq_valid, dcache_lsq_error;
    logic [3:0]  dcache_lsq_lsqid;
    logic [31:0] dcache_lsq_rdata;
    logic        aux_req;
    logic [31:0] aux_addr;
    logic        aux_ready, aux_valid, aux_error;
    logic [31:0] aux_rdata;
    logic        arb_dc_req;
    logic [3:0]  arb_dc_op;
    logic [31:0] arb_dc_addr;
    logic [4:0]  arb_dc_tag;
    logic [31:0] arb_dc_wdata;
    logic        arb_dc_flush;
    logic        dc_arb_ready, dc_arb_valid, dc_arb_error;
    logic [4:0]  dc_arb_tag;
    logic [31:0] dc_arb_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dc_port_arb #(.STARVE_LIMIT(8), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .lsq_dc_req(lsq_dc_req), .lsq_dc_op(lsq_dc_op), .lsq_dc_addr(lsq_dc_addr),
        .lsq_dc_lsqid(lsq_dc_lsqid), .lsq_dc_wdata(lsq_dc_wdata), .lsq_dc_flush(lsq_dc_flush),
        .dcache_lsq_ready(dcache_lsq_ready), .dcache_lsq_valid(dcache_lsq_valid),
        .dcache_lsq_error(dcache_lsq_error), .dcache_lsq_lsqid(dcache_lsq_lsqid),
        .dcache_lsq_rdata(dcache_lsq_rdata),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_ready(aux_ready),
        .aux_valid(aux_valid), .aux_error(aux_error), .aux_rdata(aux_rdata),
        .arb_dc_req(arb_dc_req), .arb_dc_op(arb_dc_op), .arb_dc_addr(arb_dc_addr),
        .arb_dc_tag(arb_dc_tag), .arb_dc_wdata(arb_dc_wdata), .arb_dc_flush(arb_dc_flush),
        .dc_arb_ready(dc_arb_ready), .dc_arb_valid(dc_arb_valid), .dc_arb_error(dc_arb_error),
        .dc_arb_tag(dc_arb_tag), .dc_arb_rdata(dc_arb_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lsq(input logic req, input logic [3:0] op, input logic [3:0] id,
                           input logic [31:0] addr, input logic [31:0] wdata);
        lsq_dc_req   = req;
        lsq_dc_op    = op;
        lsq_dc_lsqid = id;
        lsq_dc_addr  = addr;
        lsq_dc_wdata = wdata;
    endtask

    task automatic set_rsp(input logic valid, input logic [4:0] tag,
                           input logic [31:0] rdata, input logic err);
        dc_arb_valid = valid;
        dc_arb_tag   = tag;
        dc_arb_rdata = rdata;
        dc_arb_error = err;
    endtask

    task automatic idle();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        set_rsp(1'b0, 5'h0, 32'h0, 1'b0);
        lsq_dc_flush = 1'b0;
        aux_req      = 1'b0;
        aux_addr     = 32'h0;
        dc_arb_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        settle();

        // Reset state: everything quiet
        chk("rst_arb_req",   32'(arb_dc_req), 32'h0);
        chk("rst_lsq_ready", 32'(dcache_lsq_ready), 32'h0);
        chk("rst_aux_ready", 32'(aux_ready), 32'h0);
        chk("rst_lsq_valid", 32'(dcache_lsq_valid), 32'h0);
        chk("rst_aux_valid", 32'(aux_valid), 32'h0);
        chk("rst_tag",       32'(arb_dc_tag), 32'h0);
        chk("rst_op",        32'(arb_dc_op), 32'h0);
        chk("rst_ld_pend",   32'(dut.ld_pend), 32'h0);

        // Single LSQ load id 3
        dc_arb_ready = 1'b1;
        set_lsq(1'b1, 4'b0100, 4'd3, 32'h1000, 32'h0);
        settle();
        chk("ld3_req",   32'(arb_dc_req), 32'h1);
        chk("ld3_tag",   32'(arb_dc_tag), 32'h03);
        chk("ld3_op",    32'(arb_dc_op), 32'h4);
        chk("ld3_addr",  arb_dc_addr, 32'h1000);
        chk("ld3_ready", 32'(dcache_lsq_ready), 32'h1);
        tick();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("ld3_pend", 32'(dut.ld_pend), 32'h0008);
        tick();
        set_rsp(1'b1, 5'h03, 32'hDEADBEEF, 1'b0);
        settle();
        chk("ld3_valid", 32'(dcache_lsq_valid), 32'h1);
        chk("ld3_id",    32'(dcache_lsq_lsqid), 32'h3);
        chk("ld3_rdata", dcache_lsq_rdata, 32'hDEADBEEF);
        tick();
        set_rsp(1'b0, 5'h0, 32'h0, 1'b0);
        settle();
        chk("ld3_pend_clr", 32'(dut.ld_pend), 32'h0);

        // Starvation: LSQ stores and aux both requesting
        set_lsq(1'b1, 4'b0101, 4'd0, 32'h2000, 32'h55);
        aux_req  = 1'b1;
        aux_addr = 32'h40;
        settle();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("starve_lsq_win%0d", i), 32'(dcache_lsq_ready), 32'h1);
            chk($sformatf("starve_aux_wait%0d", i), 32'(aux_ready), 32'h0);
            tick();
        end
        chk("starve_cnt_max", 32'(dut.starve), 32'h8);
        chk("starve_aux_win", 32'(aux_ready), 32'h1);
        chk("starve_lsq_held", 32'(dcache_lsq_ready), 32'h0);
        chk("aux_tag",   32'(arb_dc_tag), 32'h10);
        chk("aux_op",    32'(arb_dc_op), 32'h4);
        chk("aux_addr",  arb_dc_addr, 32'h40);
        chk("aux_wdata", arb_dc_wdata, 32'h0);
        tick();
        chk("starve_cnt_clr", 32'(dut.starve), 32'h0);
        chk("lsq_resume", 32'(dcache_lsq_ready), 32'h1);
        chk("aux_pending_blk", 32'(aux_ready), 32'h0);
        tick();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        set_rsp(1'b1, 5'h10, 32'h12345678, 1'b1);
        settle();
        chk("aux_valid", 32'(aux_valid), 32'h1);
        chk("aux_rdata", aux_rdata, 32'h12345678);
        chk("aux_error", 32'(aux_error), 32'h1);
        chk("aux_rsp_no_lsq", 32'(dcache_lsq_valid), 32'h0);
        chk("aux_busy", 32'(aux_ready), 32'h0);
        tick();
        set_rsp(1'b0, 5'h0, 32'h0, 1'b0);
        settle();
        chk("aux_next_beat", 32'(aux_ready), 32'h1);
        tick();
        aux_req = 1'b0;
        set_rsp(1'b1, 5'h10, 32'h0BADF00D, 1'b0);
        settle();
        chk("aux_valid2", 32'(aux_valid), 32'h1);
        tick();
        set_rsp(1'b0, 5'h0, 32'h0, 1'b0);
        settle();
        chk("aux_pend_clr", 32'(dut.aux_pend), 32'h0);

        // Flush squashes load id 5
        set_lsq(1'b1, 4'b0100, 4'd5, 32'h3000, 32'h0);
        settle();
        chk("ld5_ready", 32'(dcache_lsq_ready), 32'h1);
        tick();
        lsq_dc_flush = 1'b1;
        settle();
        chk("flush_pass", 32'(arb_dc_flush), 32'h1);
        chk("flush_blocks", 32'(dcache_lsq_ready), 32'h0);
        tick();
        lsq_dc_flush = 1'b0;
        settle();
        chk("stale5", 32'(dut.stale), 32'h0020);
        chk("stale5_gate", 32'(dcache_lsq_ready), 32'h0);
        chk("stale5_noreq", 32'(arb_dc_req), 32'h0);
        set_lsq(1'b1, 4'b0101, 4'd5, 32'h3004, 32'hAA);
        settle();
        chk("stale5_store_ok", 32'(dcache_lsq_ready), 32'h1);
        tick();
        set_lsq(1'b1, 4'b0100, 4'd5, 32'h3008, 32'h0);
        set_rsp(1'b1, 5'h05, 32'h11111111, 1'b0);
        settle();
        chk("stale5_drop", 32'(dcache_lsq_valid), 32'h0);
        chk("stale5_still_gate", 32'(dcache_lsq_ready), 32'h0);
        tick();
        set_rsp(1'b0, 5'h0, 32'h0, 1'b0);
        settle();
        chk("stale5_clr", 32'(dut.stale), 32'h0);
        chk("ld5_reissue", 32'(dcache_lsq_ready), 32'h1);
        tick();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("ld5_pend_again", 32'(dut.ld_pend), 32'h0020);

        // Dcache stalled with both requesting
        set_lsq(1'b1, 4'b0101, 4'd1, 32'h4000, 32'h77);
        aux_req      = 1'b1;
        dc_arb_ready = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_req%0d", i), 32'(arb_dc_req), 32'h1);
            chk($sformatf("stall_lsq%0d", i), 32'(dcache_lsq_ready), 32'h0);
            chk($sformatf("stall_aux%0d", i), 32'(aux_ready), 32'h0);
            tick();
        end
        chk("stall_starve", 32'(dut.starve), 32'h4);
        chk("stall_pend",   32'(dut.ld_pend), 32'h0020);
        chk("stall_auxp",   32'(dut.aux_pend), 32'h0);
        dc_arb_ready = 1'b1;
        settle();
        chk("stall_rel_lsq", 32'(dcache_lsq_ready), 32'h1);
        chk("stall_rel_aux", 32'(aux_ready), 32'h0);
        tick();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        aux_req = 1'b0;

        // Flush and response for the same id in one cycle
        set_lsq(1'b1, 4'b0100, 4'd9, 32'h5000, 32'h0);
        settle();
        tick();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        lsq_dc_flush = 1'b1;
        set_rsp(1'b1, 5'h09, 32'hCAFEF00D, 1'b0);
        settle();
        chk("fr9_valid", 32'(dcache_lsq_valid), 32'h1);
        chk("fr9_rdata", dcache_lsq_rdata, 32'hCAFEF00D);
        tick();
        lsq_dc_flush = 1'b0;
        set_rsp(1'b0, 5'h0, 32'h0, 1'b0);
        settle();
        chk("fr9_stale", 32'(dut.stale), 32'h0020);
        chk("fr9_pend",  32'(dut.ld_pend), 32'h0020);

        // Reset mid-operation
        set_lsq(1'b1, 4'b0100, 4'd7, 32'h6000, 32'h0);
        settle();
        tick();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        lsq_dc_flush = 1'b1;
        settle();
        tick();
        lsq_dc_flush = 1'b0;
        set_lsq(1'b1, 4'b0100, 4'd2, 32'h7000, 32'h0);
        settle();
        tick();
        set_lsq(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("pre_rst_pend",  32'(dut.ld_pend), 32'h00A4);
        chk("pre_rst_stale", 32'(dut.stale), 32'h00A0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_pend",   32'(dut.ld_pend), 32'h0);
        chk("post_rst_stale",  32'(dut.stale), 32'h0);
        chk("post_rst_starve", 32'(dut.starve), 32'h0);
        set_rsp(1'b1, 5'h02, 32'h22222222, 1'b0);
        settle();
        chk("post_rst_rsp2_valid", 32'(dcache_lsq_valid), 32'h1);
        chk("post_rst_rsp2_id",    32'(dcache_lsq_lsqid), 32'h2);
        tick();
        set_rsp(1'b1, 5'h07, 32'h77777777, 1'b1);
        settle();
        chk("post_rst_rsp7_valid", 32'(dcache_lsq_valid), 32'h1);
        chk("post_rst_rsp7_err",   32'(dcache_lsq_error), 32'h1);
        chk("post_rst_rsp7_rdata", dcache_lsq_rdata, 32'h77777777);
        tick();
        idle();
        settle();
        chk("end_quiet", 32'(dcache_lsq_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
